// File: rtl/cpu_state_dumper.sv
// Side-band CPU state dumper: counts cycles/stalls/flushes and streams a framed
// snapshot (header, register file, data memory) over a valid/ready word port.
module cpu_state_dumper #(
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 8,
    parameter int CNT_W     = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic        dump_req_i,
    output logic        busy_o,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [31:0] dump_data_o,
    output logic [2:0]  dump_tag_o,
    output logic        dump_last_o
);
    localparam int FRAME = 4 + NUM_REGS + MEM_WORDS;
    localparam int IDX_W = $clog2(FRAME + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_REGS = 2'd2;
    localparam logic [1:0] S_MEMS = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cyc_q, stl_q, fls_q;
    logic [CNT_W-1:0] sh_stl_q, sh_fls_q;
    logic [31:0]      sh_pc_q;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [31:0]      data_q, data_d;
    logic [2:0]       tag_q, tag_d;

    int               idx_n, reg_idx, mem_idx;
    logic [31:0]      ld_data;
    logic [2:0]       ld_tag;
    logic [1:0]       ld_state;
    logic             xfer, req_take;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else if (start_i) begin
            if (cyc_q != CNT_MAX)            cyc_q <= cyc_q + 1'b1;
            if (stall_i && stl_q != CNT_MAX) stl_q <= stl_q + 1'b1;
            if (flush_i && fls_q != CNT_MAX) fls_q <= fls_q + 1'b1;
        end
    end

    assign req_take = (state_q == S_IDLE) && dump_req_i;
    assign xfer     = valid_q && dump_ready_i;

    // Word 0 goes straight into the output register; only words 1..3 need shadows.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sh_stl_q <= '0;
            sh_fls_q <= '0;
            sh_pc_q  <= '0;
        end else if (req_take) begin
            sh_stl_q <= stl_q;
            sh_fls_q <= fls_q;
            sh_pc_q  <= pc_i;
        end
    end

    // idx_q is the frame position of the next word to load; read ports follow it.
    always_comb begin
        idx_n   = int'(idx_q);
        reg_idx = idx_n - 4;
        if (reg_idx < 0) reg_idx = 0;
        else if (reg_idx > NUM_REGS - 1) reg_idx = NUM_REGS - 1;
        mem_idx = idx_n - 4 - NUM_REGS;
        if (mem_idx < 0) mem_idx = 0;
        else if (mem_idx > MEM_WORDS - 1) mem_idx = MEM_WORDS - 1;
    end

    assign reg_addr_o = 5'(reg_idx);
    assign mem_addr_o = 32'(mem_idx) << 2;

    always_comb begin
        ld_data  = mem_data_i;
        ld_tag   = 3'd5;
        ld_state = S_MEMS;
        if (idx_n < 4) begin
            ld_tag   = 3'(idx_n);
            ld_state = S_HDR;
            case (idx_n)
                1:       ld_data = 32'(sh_stl_q);
                2:       ld_data = 32'(sh_fls_q);
                default: ld_data = sh_pc_q;
            endcase
        end else if (idx_n < 4 + NUM_REGS) begin
            ld_data  = reg_data_i;
            ld_tag   = 3'd4;
            ld_state = S_REGS;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (req_take) begin
            state_d = S_HDR;
            idx_d   = IDX_W'(1);
            valid_d = 1'b1;
            last_d  = 1'b0;
            data_d  = 32'(cyc_q);
            tag_d   = 3'd0;
        end else if (state_q != S_IDLE && xfer) begin
            if (last_q) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                state_d = ld_state;
                idx_d   = IDX_W'(idx_n + 1);
                data_d  = ld_data;
                tag_d   = ld_tag;
                last_d  = (idx_n == FRAME - 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign dump_valid_o = valid_q;
    assign dump_data_o  = data_q;
    assign dump_tag_o   = tag_q;
    assign dump_last_o  = last_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: counter model plus frame reference built from
// the snapshot values and the register/memory model arrays.
module tb_cpu_state_dumper;
    localparam int FRAME = 44;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stall, flush, req, ready;
    logic [31:0] pc;

    logic        busy1, valid1, last1, busy2, valid2, last2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, maddr1, mdata1, data1, rdata2, maddr2, mdata2, data2;
    logic [2:0]  tag1, tag2;

    logic [31:0] rf [32];
    logic [31:0] dm [8];

    assign rdata1 = rf[raddr1];
    assign mdata1 = (maddr1 < 32'd32) ? dm[maddr1[4:2]] : 32'hBAD0_BAD0;
    assign rdata2 = rf[raddr2];
    assign mdata2 = (maddr2 < 32'd32) ? dm[maddr2[4:2]] : 32'hBAD0_BAD0;

    cpu_state_dumper dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
        .pc_i(pc), .dump_req_i(req), .busy_o(busy1), .reg_addr_o(raddr1),
        .reg_data_i(rdata1), .mem_addr_o(maddr1), .mem_data_i(mdata1),
        .dump_valid_o(valid1), .dump_ready_i(ready), .dump_data_o(data1),
        .dump_tag_o(tag1), .dump_last_o(last1)
    );

    cpu_state_dumper #(.CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
        .pc_i(pc), .dump_req_i(req), .busy_o(busy2), .reg_addr_o(raddr2),
        .reg_data_i(rdata2), .mem_addr_o(maddr2), .mem_data_i(mdata2),
        .dump_valid_o(valid2), .dump_ready_i(ready), .dump_data_o(data2),
        .dump_tag_o(tag2), .dump_last_o(last2)
    );

    int          nvec = 0, nerr = 0;
    longint      m_cyc, m_stl, m_fls, s_cyc, s_stl, s_fls;
    logic [31:0] s_pc;
    logic [31:0] rx_d[$], exp_d[$];
    logic [2:0]  rx_t[$], exp_t[$];
    logic        rx_l[$];

    task automatic tick();
        if (req && !busy1) begin
            s_cyc = m_cyc; s_stl = m_stl; s_fls = m_fls; s_pc = pc;
        end
        if (start) begin
            m_cyc++;
            if (stall) m_stl++;
            if (flush) m_fls++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 0; ready = 0; start = 0; stall = 0; flush = 0; pc = '0;
        m_cyc = 0; m_stl = 0; m_fls = 0;
        #13;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Requests a frame and collects it; optionally pulses a second request or aborts.
    task automatic run_frame(input bit rnd, input int pulse_at, input int abort_at,
                             output int cycles, output bit aborted);
        logic [31:0] d, pd;
        logic [2:0]  t, pt;
        logic        v, l, r, have_prev, done;
        req = 1'b1;
        tick();
        req = 1'b0;
        nvec++;
        if (valid1 !== 1'b1) begin
            nerr++; $display("FAIL first_valid: got %b want 1", valid1);
        end
        exp_d = {}; exp_t = {};
        exp_d.push_back(32'(s_cyc)); exp_d.push_back(32'(s_stl));
        exp_d.push_back(32'(s_fls)); exp_d.push_back(s_pc);
        for (int i = 0; i < 4; i++) exp_t.push_back(3'(i));
        for (int i = 0; i < 32; i++) begin exp_d.push_back(rf[i]); exp_t.push_back(3'd4); end
        for (int i = 0; i < 8; i++)  begin exp_d.push_back(dm[i]); exp_t.push_back(3'd5); end
        rx_d = {}; rx_t = {}; rx_l = {};
        cycles = 0; done = 0; have_prev = 0; aborted = 0; pd = '0; pt = '0;
        while (!done && cycles < 500) begin
            if (abort_at >= 0 && rx_d.size() == abort_at) begin
                #2;
                rst_n = 1'b0;
                m_cyc = 0; m_stl = 0; m_fls = 0;
                #1;
                nvec++;
                if (valid1 !== 1'b0 || busy1 !== 1'b0 || raddr1 !== 5'd0 || maddr1 !== 32'd0) begin
                    nerr++;
                    $display("FAIL async_abort: valid=%b busy=%b raddr=%0d maddr=%0h want 0", valid1, busy1, raddr1, maddr1);
                end
                aborted = 1;
                return;
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            req   = (pulse_at >= 0 && rx_d.size() == pulse_at);
            if (have_prev) begin
                nvec++;
                if (data1 !== pd || tag1 !== pt) begin
                    nerr++;
                    $display("FAIL stall_hold: data=%h tag=%0d want data=%h tag=%0d", data1, tag1, pd, pt);
                end
            end
            v = valid1; d = data1; t = tag1; l = last1; r = ready;
            tick();
            cycles++;
            req = 1'b0;
            have_prev = 0;
            if (v && r) begin
                rx_d.push_back(d); rx_t.push_back(t); rx_l.push_back(l);
                if (l) done = 1;
            end else if (v) begin
                have_prev = 1; pd = d; pt = t;
            end
        end
        ready = 1'b0;
        nvec++;
        if (!done) begin
            nerr++; $display("FAIL frame_timeout: got %0d words want %0d", rx_d.size(), FRAME);
            return;
        end
        nvec++;
        if (rx_d.size() != FRAME) begin
            nerr++; $display("FAIL frame_len: got %0d want %0d", rx_d.size(), FRAME);
        end
        for (int i = 0; i < rx_d.size() && i < FRAME; i++) begin
            nvec++;
            if (rx_d[i] !== exp_d[i] || rx_t[i] !== exp_t[i] || rx_l[i] !== (i == FRAME - 1)) begin
                nerr++;
                $display("FAIL word%0d: data=%h tag=%0d last=%b want data=%h tag=%0d last=%b",
                         i, rx_d[i], rx_t[i], rx_l[i], exp_d[i], exp_t[i], i == FRAME - 1);
            end
        end
        nvec++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
            nerr++; $display("FAIL frame_end: valid=%b busy=%b want 0 0", valid1, busy1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if (valid1 !== 0 || busy1 !== 0 || last1 !== 0 || data1 !== 0 || tag1 !== 0 ||
            raddr1 !== 0 || maddr1 !== 0) begin
            nerr++;
            $display("FAIL reset_state: v=%b b=%b l=%b d=%h t=%0d ra=%0d ma=%h want all 0",
                     valid1, busy1, last1, data1, tag1, raddr1, maddr1);
        end
    endtask

    task automatic test_header();
        int cyc; bit ab;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stall = (i == 0 || i == 3 || i == 7);
            flush = (i == 2 || i == 5);
            tick();
        end
        start = 0; stall = 0; flush = 0;
        pc = $urandom;
        run_frame(1'b0, -1, -1, cyc, ab);
        nvec++;
        if (rx_d.size() < 4 || rx_d[0] !== 32'd10 || rx_d[1] !== 32'd3 || rx_d[2] !== 32'd2 || rx_d[3] !== pc) begin
            nerr++;
            $display("FAIL header: got %0d,%0d,%0d,%h want 10,3,2,%h",
                     rx_d.size() > 0 ? rx_d[0] : 0, rx_d.size() > 1 ? rx_d[1] : 0,
                     rx_d.size() > 2 ? rx_d[2] : 0, rx_d.size() > 3 ? rx_d[3] : 0, pc);
        end
        nvec++;
        if (cyc != FRAME) begin
            nerr++; $display("FAIL back_to_back_cycles: got %0d want %0d", cyc, FRAME);
        end
    endtask

    task automatic test_preload();
        int cyc; bit ab;
        rf[5] = 32'h1234;
        dm[7] = 32'hDEADBEEF;
        pc = $urandom;
        run_frame(1'b0, -1, -1, cyc, ab);
        nvec++;
        if (rx_d.size() != FRAME || rx_d[9] !== 32'h1234 || rx_t[9] !== 3'd4) begin
            nerr++; $display("FAIL reg5_word: got %h want 00001234 tag 4", rx_d.size() > 9 ? rx_d[9] : 32'h0);
        end
        nvec++;
        if (rx_d.size() != FRAME || rx_d[43] !== 32'hDEADBEEF || rx_t[43] !== 3'd5 || rx_l[43] !== 1'b1) begin
            nerr++; $display("FAIL mem7_word: got %h want deadbeef tag 5 last 1", rx_d.size() > 43 ? rx_d[43] : 32'h0);
        end
    endtask

    task automatic test_random_ready();
        int cyc; bit ab;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            for (int i = 0; i < 8; i++)  dm[i] = $urandom;
            start = 1'b1;
            for (int i = 0; i < 5 + k; i++) begin
                stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
                tick();
            end
            stall = 0; flush = 0;
            start = 1'($urandom_range(0, 1));
            pc = $urandom;
            run_frame(1'b1, -1, -1, cyc, ab);
        end
        start = 0;
    endtask

    task automatic test_req_while_busy();
        int cyc; bit ab;
        pc = $urandom;
        run_frame(1'b0, 10, -1, cyc, ab);
        for (int i = 0; i < 2; i++) begin
            tick();
            nvec++;
            if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
                nerr++; $display("FAIL req_ignored: busy=%b valid=%b want 0 0", busy1, valid1);
            end
        end
        pc = $urandom;
        run_frame(1'b0, -1, -1, cyc, ab);
    endtask

    task automatic test_abort();
        int cyc; bit ab;
        start = 1'b1; stall = 1'b1; flush = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        start = 0; stall = 0; flush = 0;
        pc = $urandom;
        run_frame(1'b0, -1, 20, cyc, ab);
        #2;
        rst_n = 1'b1;
        tick();
        nvec++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
            nerr++; $display("FAIL no_resume: busy=%b valid=%b want 0 0", busy1, valid1);
        end
        pc = $urandom;
        run_frame(1'b0, -1, -1, cyc, ab);
        nvec++;
        if (rx_d.size() < 3 || rx_d[0] !== 0 || rx_d[1] !== 0 || rx_d[2] !== 0) begin
            nerr++;
            $display("FAIL counters_cleared: got %0d,%0d,%0d want 0,0,0",
                     rx_d.size() > 0 ? rx_d[0] : 0, rx_d.size() > 1 ? rx_d[1] : 0, rx_d.size() > 2 ? rx_d[2] : 0);
        end
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stall = (i < 17);
            flush = (i < 6);
            tick();
        end
        start = 0; stall = 0; flush = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        nvec++;
        if (data2 !== 32'd15 || tag2 !== 3'd0 || valid2 !== 1'b1) begin
            nerr++; $display("FAIL sat_cycle: got %0d tag %0d want 15 tag 0", data2, tag2);
        end
        nvec++;
        if (data1 !== 32'd20) begin
            nerr++; $display("FAIL wide_cycle: got %0d want 20", data1);
        end
        ready = 1'b1;
        tick();
        nvec++;
        if (data2 !== 32'(s_stl > 15 ? 15 : s_stl) || tag2 !== 3'd1) begin
            nerr++; $display("FAIL sat_stall: got %0d tag %0d want 15 tag 1", data2, tag2);
        end
        tick();
        nvec++;
        if (data2 !== 32'(s_fls > 15 ? 15 : s_fls) || tag2 !== 3'd2) begin
            nerr++; $display("FAIL sat_flush: got %0d tag %0d want 6 tag 2", data2, tag2);
        end
        n = 0;
        while ((busy1 || busy2) && n < 100) begin tick(); n++; end
        ready = 1'b0;
        nvec++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            nerr++; $display("FAIL sat_frame_end: busy1=%b busy2=%b want 0 0", busy1, busy2);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 8; i++)  dm[i] = $urandom;
        test_reset();
        test_header();
        test_preload();
        test_random_ready();
        test_req_while_busy();
        test_abort();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
